axi4_lite_regfile_sub: RTL
==========================

Name: axi4_lite_regfile_sub

Overview:
Parametrised AXI4-Lite subordinate register file; next generation of the fixed 4-register, 32-bit interface. Configurable register count, data width, per-register read-only mask, byte-strobed writes, and decode-error handling. Sits between the AXI interconnect/VIP master and user logic, exposing flattened register outputs, read-only inputs, and per-register access pulses.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64 only.
ADDR_WIDTH, 8, AXI address width; must cover NUM_REGS*DATA_WIDTH/8 bytes.
NUM_REGS, 8, number of registers, 1..64.
RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only; it reads reg_in[i].

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  reset; synchronous, active-high
AWADDR  in  ADDR_WIDTH  write address
AWPROT  in  3  accepted, ignored
AWVALID/AWREADY  in/out  1  write address handshake
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte enables
WVALID/WREADY  in/out  1  write data handshake
BRESP  out  2  write response
BVALID/BREADY  out/in  1  write response handshake
ARADDR  in  ADDR_WIDTH  read address
ARPROT  in  3  accepted, ignored
ARVALID/ARREADY  in/out  1  read address handshake
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID/RREADY  out/in  1  read data handshake
reg_out  out  NUM_REGS*DATA_WIDTH  register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
reg_in  in  NUM_REGS*DATA_WIDTH  read-only sources, same slicing
reg_wr_pulse  out  NUM_REGS  1-cycle pulse on committed write to writable reg i
reg_rd_pulse  out  NUM_REGS  1-cycle pulse on read-address acceptance of reg i

Behaviour:
- Reset (ARESET=1 at edge): all outputs 0, reg_out=0, both FSMs to idle, holding regs cleared. In-flight transactions are abandoned; BVALID/RVALID drop with no response. Reset overrides every simultaneous event.
- Decode: ADDR_LSB=clog2(DATA_WIDTH/8). idx=addr[ADDR_WIDTH-1:ADDR_LSB]; low bits ignored. idx>=NUM_REGS means out of range.
- Write FSM W_IDLE -> W_COMMIT -> W_RESP:
  - W_IDLE: AWREADY=1 until AW captured; WREADY=1 until W captured. AW and W are captured independently in either order or in the same cycle.
  - Both captured -> W_COMMIT. Commit lasts one cycle: bytes with WSTRB=1 update a writable in-range register; reg_wr_pulse[idx]=1. RO or out-of-range targets are not updated and get no pulse.
  - W_RESP: BVALID=1 with BRESP held until BREADY; then W_IDLE.
  - Latency: AW+W handshake at edge N -> reg_out updated and BVALID high after edge N+1. AWREADY/WREADY are 0 outside W_IDLE.
  - One outstanding write only.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. On handshake, RDATA latches at the same edge from reg_out (writable) or reg_in (RO); reg_rd_pulse[idx]=1 for one cycle.
  - R_DATA: RVALID=1 with RDATA/RRESP stable until RREADY; then R_IDLE.
  - Latency: RVALID high one cycle after AR handshake. One outstanding read.
- Read and write FSMs are fully independent. If a read handshake and a write commit to the same register fall on the same edge, the read returns the pre-write value.
- Write to RO register: OKAY response, no effect.

Optional Feature:
Macro AXI_REGFILE_DECERR_EN.
- Defined: out-of-range access gives BRESP/RRESP=2'b11 (DECERR) and RDATA=0.
- Undefined: out-of-range access gives OKAY and RDATA=0; writes are silently dropped.
- In-range behaviour is identical in both cases.

Decomposition:
- Package axi4_lite_regfile_pkg: resp_t enum (OKAY=0, SLVERR=2, DECERR=3), write/read FSM state enums, helper function addr_to_idx.
- Sub-module axi4_lite_wr_capture: AW/W independent capture-and-hold with a both-valid flag. Instantiated once.

Test Plan:
- Default params; write 1,2,3,4 to 0x0,0x4,0x8,0xC; read back -> RDATA 1,2,3,4, RRESP=0, reg_wr_pulse bits 0..3 one cycle each.
- W at cycle 3, AW at cycle 7 (addr 0x10, data 0xA5A5A5A5) -> single commit after edge 8, reg_out[4]=0xA5A5A5A5, BVALID after edge 8.
- reg 2 = 0xFFFFFFFF; write 0x12345678 with WSTRB=4'b0101 -> reg 2 reads 0xFF34FF78.
- RO_MASK bit 1 set, reg_in[1]=0xDEADBEEF; write 0x0 to 0x4 -> BRESP=0, no pulse; read 0x4 -> 0xDEADBEEF.
- NUM_REGS=8; read 0x20 -> RDATA=0, RRESP=3 with macro defined, 0 without.
- BREADY held low 10 cycles, ARESET pulsed at cycle 5 -> BVALID=0 from next cycle, reg_out=0, AWREADY=WREADY=1 after reset deasserts.

Source files
------------

// File: rtl/axi4_lite_regfile_pkg.sv
// Shared types for the AXI4-Lite register file: response codes, FSM states and address decode.
// Optional decode-error responses are enabled with the AXI_REGFILE_DECERR_EN macro in the top.
package axi4_lite_regfile_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef struct packed {
        wr_state_e wr_state;
        rd_state_e rd_state;
    } fsm_dbg_t;

    // Word index of a byte address; sub-word address bits are discarded.
    function automatic int unsigned addr_to_idx(input logic [63:0] addr, input int unsigned addr_lsb);
        return 32'(addr >> addr_lsb);
    endfunction

endpackage

// File: rtl/axi4_lite_wr_capture.sv
// Captures the AW and W channels independently (any order, or together) and holds them
// until the owning write FSM commits; both_valid also sees same-cycle handshakes.
module axi4_lite_wr_capture
    import axi4_lite_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         accept_en,
    input  logic                         clear,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/BYTE_W-1:0] wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [ADDR_WIDTH-1:0]        addr,
    output logic [DATA_WIDTH-1:0]        data,
    output logic [DATA_WIDTH/BYTE_W-1:0] strb,
    output logic                         both_valid
);

    logic                         aw_held_q, aw_held_d;
    logic                         w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        data_q, data_d;
    logic [DATA_WIDTH/BYTE_W-1:0] strb_q, strb_d;
    logic                         aw_hs, w_hs;

    assign awready    = accept_en && !aw_held_q;
    assign wready     = accept_en && !w_held_q;
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign both_valid = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        if (clear) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                addr_d    = awaddr;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                data_d   = wdata;
                strb_d   = wstrb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

    assign addr = addr_q;
    assign data = data_q;
    assign strb = strb_q;

endmodule

// File: rtl/axi4_lite_regfile_sub.sv
// Parametrised AXI4-Lite subordinate register file with read-only mask and byte strobes.
// Define AXI_REGFILE_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axi4_lite_regfile_sub
    import axi4_lite_regfile_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = {NUM_REGS{1'b0}}
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            reg_wr_pulse,
    output logic [NUM_REGS-1:0]            reg_rd_pulse
);

    localparam int unsigned STRB_W   = DATA_WIDTH / BYTE_W;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int          IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
`ifdef AXI_REGFILE_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid sources hold payload stable until then, and ready never depends on valid.
    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    fsm_dbg_t  fsm_dbg;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] reg_in_a [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
    resp_t                 bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_data, byte_mask;
    logic [STRB_W-1:0]     cap_strb;
    logic                  cap_both_valid;
    int unsigned           wr_idx_full, rd_idx_full;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  wr_in_range, wr_writable, rd_in_range, ar_hs;
    logic                  unused_ok;

    axi4_lite_wr_capture #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wr_capture (
        .clk       (ACLK),
        .rst       (ARESET),
        .accept_en (wr_state_q == W_IDLE && !ARESET),
        .clear     (wr_state_q == W_COMMIT),
        .awaddr    (AWADDR),
        .awvalid   (AWVALID),
        .awready   (AWREADY),
        .wdata     (WDATA),
        .wstrb     (WSTRB),
        .wvalid    (WVALID),
        .wready    (WREADY),
        .addr      (cap_addr),
        .data      (cap_data),
        .strb      (cap_strb),
        .both_valid(cap_both_valid)
    );

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
        assign reg_in_a[gi] = reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign wr_idx_full = addr_to_idx(64'(cap_addr), ADDR_LSB);
    assign wr_idx      = wr_idx_full[IDX_W-1:0];
    assign wr_in_range = wr_idx_full < NUM_REGS;
    assign wr_writable = wr_in_range && !RO_MASK[wr_idx];

    always_comb begin
        wr_state_d = wr_state_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        bresp_d    = bresp_q;
        byte_mask  = '0;
        for (int b = 0; b < STRB_W; b++) begin
            byte_mask[b*BYTE_W +: BYTE_W] = {BYTE_W{cap_strb[b]}};
        end
        case (wr_state_q)
            W_IDLE: if (cap_both_valid) wr_state_d = W_COMMIT;
            W_COMMIT: begin
                if (wr_writable) begin
                    regs_d[wr_idx]     = (regs_q[wr_idx] & ~byte_mask) | (cap_data & byte_mask);
                    wr_pulse_d[wr_idx] = 1'b1;
                end
                bresp_d    = (!wr_in_range && DECERR_EN) ? RESP_DECERR : RESP_OKAY;
                wr_state_d = W_RESP;
            end
            W_RESP: if (BREADY) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign ARREADY     = (rd_state_q == R_IDLE) && !ARESET;
    assign ar_hs       = ARVALID && ARREADY;
    assign rd_idx_full = addr_to_idx(64'(ARADDR), ADDR_LSB);
    assign rd_idx      = rd_idx_full[IDX_W-1:0];
    assign rd_in_range = rd_idx_full < NUM_REGS;

    // Read data is taken from the pre-commit register value, so a same-edge write is not visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_pulse_d = '0;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_DATA;
                    if (rd_in_range) begin
                        rdata_d            = RO_MASK[rd_idx] ? reg_in_a[rd_idx] : regs_q[rd_idx];
                        rresp_d            = RESP_OKAY;
                        rd_pulse_d[rd_idx] = 1'b1;
                    end else begin
                        rdata_d = '0;
                        rresp_d = DECERR_EN ? RESP_DECERR : RESP_OKAY;
                    end
                end
            end
            R_DATA: if (RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            regs_q     <= '{default: '0};
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign BVALID       = (wr_state_q == W_RESP);
    assign BRESP        = bresp_q;
    assign RVALID       = (rd_state_q == R_DATA);
    assign RRESP        = rresp_q;
    assign RDATA        = rdata_q;
    assign reg_wr_pulse = wr_pulse_q;
    assign reg_rd_pulse = rd_pulse_q;

    assign fsm_dbg = '{wr_state: wr_state_q, rd_state: rd_state_q};
    // Protection bits have no meaning here; the index upper bits only feed the range compare.
    assign unused_ok = ^{AWPROT, ARPROT, fsm_dbg, wr_idx_full, rd_idx_full};

endmodule
